// File: rtl/sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_config_sequencer
// Description : Walks a combinational configuration table and turns every
//               {reg, val} entry into a 3-phase SCCB write request for a
//               byte-level SCCB master. Entry 16'hFFFF ends the table and
//               entry 16'hFFF0 inserts a DELAY_MS wait. While idle or done,
//               single-register host writes are also accepted.
// Options     : `define SCCB_RETRY_EN to re-issue a nacked table entry up to
//               3 times before flagging error. Host writes are never retried.
// Ports       : clk, rst_n (async, active low)
//               start                      - pulse, (re)runs the table
//               rom_addr / rom_data        - table index / entry (same cycle)
//               host_req, host_data        - runtime write request
//               host_ack                   - one-cycle completion pulse
//               sccb_req, sccb_data        - request {SLAVE_ID, reg, val}
//               sccb_ack, sccb_nack        - master completion / missed ACK
//               busy, config_done, error   - status
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_config_sequencer #(
  parameter int         CLK_HZ   = 100000000,
  parameter int         DELAY_MS = 10,
  parameter logic [7:0] SLAVE_ID = 8'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        host_req,
  input  logic [15:0] host_data,
  output logic        host_ack,
  output logic        sccb_req,
  output logic [23:0] sccb_data,
  input  logic        sccb_ack,
  input  logic        sccb_nack,
  output logic        busy,
  output logic        config_done,
  output logic        error
);

  localparam int DELAY_CYCLES = CLK_HZ / 1000 * DELAY_MS;
  localparam int CNT_W        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DELAY = 3'd4;
  localparam logic [2:0] S_HOST  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic             sccb_req_q, sccb_req_d;
  logic [23:0]      sccb_data_q, sccb_data_d;
  logic             host_ack_q, host_ack_d;
  logic             config_done_q, config_done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;
  logic             host_ret_q, host_ret_d;   // 1: return to DONE after host write
`ifdef SCCB_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    sccb_req_d    = sccb_req_q;
    sccb_data_d   = sccb_data_q;
    host_ack_d    = 1'b0;
    config_done_d = config_done_q;
    error_d       = error_q;
    dly_cnt_d     = dly_cnt_q;
    host_ret_d    = host_ret_q;
`ifdef SCCB_RETRY_EN
    retry_d       = retry_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_FETCH;
          rom_addr_d    = 8'd0;
          config_done_d = 1'b0;
          error_d       = 1'b0;
`ifdef SCCB_RETRY_EN
          retry_d       = 2'd0;
`endif
        end else if (host_req && !host_ack_q) begin
          // host_ack_q blocks re-accepting a request the host has not yet
          // had a chance to drop after seeing its ack.
          state_d     = S_HOST;
          host_ret_d  = (state_q == S_DONE);
          sccb_req_d  = 1'b1;
          sccb_data_d = {SLAVE_ID, host_data};
        end
      end

      S_FETCH: begin
        if (rom_data == ENTRY_END) begin
          state_d       = S_DONE;
          config_done_d = 1'b1;
        end else if (rom_data == ENTRY_DELAY) begin
          state_d   = S_DELAY;
          dly_cnt_d = DELAY_LOAD;
        end else begin
          state_d     = S_ISSUE;
          sccb_req_d  = 1'b1;
          sccb_data_d = {SLAVE_ID, rom_data};
        end
      end

      S_ISSUE: begin
        if (sccb_req_q && sccb_ack) begin
          sccb_req_d = 1'b0;
`ifdef SCCB_RETRY_EN
          if (sccb_nack && (retry_q != 2'd3)) begin
            // Stay in ISSUE with req low for one cycle, then re-raise it
            // with the same data.
            retry_d = retry_q + 2'd1;
          end else begin
            if (sccb_nack) begin
              error_d = 1'b1;
            end
            retry_d = 2'd0;
            state_d = S_WAIT;
          end
`else
          if (sccb_nack) begin
            error_d = 1'b1;
          end
          state_d = S_WAIT;
`endif
        end
`ifdef SCCB_RETRY_EN
        else if (!sccb_req_q) begin
          sccb_req_d = 1'b1;
        end
`endif
      end

      S_WAIT: begin
        if (rom_addr_q == 8'hFF) begin
          state_d       = S_DONE;
          config_done_d = 1'b1;
        end else begin
          rom_addr_d = rom_addr_q + 8'd1;
          state_d    = S_FETCH;
        end
      end

      S_DELAY: begin
        if (dly_cnt_q == '0) begin
          if (rom_addr_q == 8'hFF) begin
            state_d       = S_DONE;
            config_done_d = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end else begin
          dly_cnt_d = dly_cnt_q - 1'b1;
        end
      end

      S_HOST: begin
        if (sccb_ack) begin
          sccb_req_d = 1'b0;
          host_ack_d = 1'b1;
          if (sccb_nack) begin
            error_d = 1'b1;
          end
          state_d = host_ret_q ? S_DONE : S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        sccb_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= 8'd0;
      sccb_req_q    <= 1'b0;
      sccb_data_q   <= 24'd0;
      host_ack_q    <= 1'b0;
      config_done_q <= 1'b0;
      error_q       <= 1'b0;
      dly_cnt_q     <= '0;
      host_ret_q    <= 1'b0;
`ifdef SCCB_RETRY_EN
      retry_q       <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      sccb_req_q    <= sccb_req_d;
      sccb_data_q   <= sccb_data_d;
      host_ack_q    <= host_ack_d;
      config_done_q <= config_done_d;
      error_q       <= error_d;
      dly_cnt_q     <= dly_cnt_d;
      host_ret_q    <= host_ret_d;
`ifdef SCCB_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign rom_addr    = rom_addr_q;
  assign sccb_req    = sccb_req_q;
  assign sccb_data   = sccb_data_q;
  assign host_ack    = host_ack_q;
  assign config_done = config_done_q;
  assign error       = error_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_config_sequencer
// Description : Directed bench for sccb_config_sequencer. A table model feeds
//               rom_data, a simple SCCB master model acks after a set
//               latency (optionally with nack) and logs every issued request
//               together with the number of req-low cycles preceding it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        host_req = 1'b0;
  logic [15:0] host_data = 16'd0;
  logic        host_ack;
  logic        sccb_req;
  logic [23:0] sccb_data;
  logic        sccb_ack = 1'b0;
  logic        sccb_nack = 1'b0;
  logic        busy;
  logic        config_done;
  logic        error;

  logic [15:0] rom [256];
  assign rom_data = rom[rom_addr];

  sccb_config_sequencer #(
    .CLK_HZ   (1000000),
    .DELAY_MS (2),
    .SLAVE_ID (8'h42)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .host_req    (host_req),
    .host_data   (host_data),
    .host_ack    (host_ack),
    .sccb_req    (sccb_req),
    .sccb_data   (sccb_data),
    .sccb_ack    (sccb_ack),
    .sccb_nack   (sccb_nack),
    .busy        (busy),
    .config_done (config_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // ---------------- SCCB master model ----------------
  int          ack_lat   = 5;
  int          nack_left = 0;
  logic        master_en = 1'b1;
  int          lat_cnt   = 0;
  logic        req_prev  = 1'b0;
  int          gap_cnt   = 0;
  logic [23:0] iss_data [$];
  int          iss_gap  [$];

  always @(negedge clk) begin
    sccb_ack  = 1'b0;
    sccb_nack = 1'b0;
    if (sccb_req && !req_prev) begin
      iss_data.push_back(sccb_data);
      iss_gap.push_back(gap_cnt);
      gap_cnt = 0;
    end
    if (!sccb_req) gap_cnt++;
    req_prev = sccb_req;
    if (!rst_n || !master_en || !sccb_req) begin
      lat_cnt = 0;
    end else if (lat_cnt == ack_lat - 1) begin
      sccb_ack = 1'b1;
      if (nack_left > 0) begin
        sccb_nack = 1'b1;
        nack_left--;
      end
      lat_cnt = 0;
    end else begin
      lat_cnt++;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max, input string tag);
    for (int i = 0; i < max && busy; i++) @(negedge clk);
    check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_host_ack(input int max, input string tag);
    for (int i = 0; i < max && !host_ack; i++) @(negedge clk);
    check({tag, "_host_ack"}, {31'd0, host_ack}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    iss_data.delete();
    iss_gap.delete();
  endtask

  int n_before;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_rom_addr",    {24'd0, rom_addr},   32'd0);
    check("rst_sccb_req",    {31'd0, sccb_req},   32'd0);
    check("rst_sccb_data",   {8'd0, sccb_data},   32'd0);
    check("rst_host_ack",    {31'd0, host_ack},   32'd0);
    check("rst_busy",        {31'd0, busy},       32'd0);
    check("rst_config_done", {31'd0, config_done}, 32'd0);
    check("rst_error",       {31'd0, error},      32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- basic table {1204,1100,FFFF} ----------------
    rom[0] = 16'h1204; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
    clear_log();
    pulse_start();
    check("t1_busy",        {31'd0, busy},        32'd1);
    check("t1_rom_addr",    {24'd0, rom_addr},    32'd0);
    check("t1_config_done", {31'd0, config_done}, 32'd0);
    wait_idle(200, "t1");
    check("t1_n_issued",   iss_data.size(),      32'd2);
    check("t1_data0",      {8'd0, iss_data[0]},  32'h421204);
    check("t1_data1",      {8'd0, iss_data[1]},  32'h421100);
    check("t1_done",       {31'd0, config_done}, 32'd1);
    check("t1_error",      {31'd0, error},       32'd0);
    check("t1_rom_addr_end", {24'd0, rom_addr},  32'd2);

    // ---------------- delay entry {1280,FFF0,1204,FFFF} ----------------
    // Counter loads 1000000/1000*2-1 = 1999, so DELAY lasts 2000 cycles.
    // Req-low cycles between the writes: WAIT + FETCH(FFF0) + 2000 + FETCH = 2003.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    clear_log();
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();   // mid-run start must be ignored
    wait_idle(3000, "t2");
    check("t2_n_issued", iss_data.size(),     32'd2);
    check("t2_data0",    {8'd0, iss_data[0]}, 32'h421280);
    check("t2_data1",    {8'd0, iss_data[1]}, 32'h421204);
    check("t2_gap",      iss_gap[1],          32'd2003);
    check("t2_done",     {31'd0, config_done}, 32'd1);
    check("t2_rom_addr_end", {24'd0, rom_addr}, 32'd3);

    // ---------------- nack on entry 0 ----------------
    rom[0] = 16'h1204; rom[1] = 16'hFFFF;
    clear_log();
    nack_left = 4;
    pulse_start();
    check("t3_error_cleared", {31'd0, error}, 32'd0);
    wait_idle(300, "t3");
`ifdef SCCB_RETRY_EN
    check("t3_n_issued", iss_data.size(), 32'd4);
    check("t3_data_last", {8'd0, iss_data[3]}, 32'h421204);
`else
    check("t3_n_issued", iss_data.size(), 32'd1);
`endif
    check("t3_data0",    {8'd0, iss_data[0]}, 32'h421204);
    check("t3_error",    {31'd0, error},      32'd1);
    check("t3_rom_addr", {24'd0, rom_addr},   32'd1);
    check("t3_done",     {31'd0, config_done}, 32'd1);
    nack_left = 0;

    // ---------------- reset during ISSUE ----------------
    master_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 20 && !sccb_req; i++) @(negedge clk);
    check("t4_req_before", {31'd0, sccb_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_req",        {31'd0, sccb_req},    32'd0);
    check("t4_data",       {8'd0, sccb_data},    32'd0);
    check("t4_busy",       {31'd0, busy},        32'd0);
    check("t4_rom_addr",   {24'd0, rom_addr},    32'd0);
    check("t4_done",       {31'd0, config_done}, 32'd0);
    check("t4_error",      {31'd0, error},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    master_en = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_stay_idle",  {31'd0, busy},        32'd0);
    check("t4_stay_req",   {31'd0, sccb_req},    32'd0);

    // ---------------- start and host_req together in IDLE ----------------
    rom[0] = 16'h1204; rom[1] = 16'hFFFF;
    clear_log();
    host_data = 16'h8C00;
    host_req  = 1'b1;
    pulse_start();
    wait_idle(200, "t5");
    check("t5_config_first", iss_data.size(),     32'd1);
    check("t5_data0",        {8'd0, iss_data[0]}, 32'h421204);
    check("t5_done",         {31'd0, config_done}, 32'd1);
    wait_host_ack(50, "t5");
    host_req = 1'b0;
    check("t5_n_issued",     iss_data.size(),     32'd2);
    check("t5_host_data",    {8'd0, iss_data[1]}, 32'h428C00);
    check("t5_error",        {31'd0, error},      32'd0);
    check("t5_done_kept",    {31'd0, config_done}, 32'd1);
    @(negedge clk);
    check("t5_ack_pulse",    {31'd0, host_ack},   32'd0);
    check("t5_busy",         {31'd0, busy},       32'd0);

    // ---------------- host write with nack: error, no retry ----------------
    n_before  = iss_data.size();
    nack_left = 1;
    host_data = 16'h1234;
    host_req  = 1'b1;
    @(negedge clk);
    check("t6_busy", {31'd0, busy}, 32'd1);
    wait_host_ack(50, "t6");
    host_req = 1'b0;
    check("t6_error", {31'd0, error}, 32'd1);
    repeat (20) @(negedge clk);
    check("t6_single_issue", iss_data.size(), n_before + 1);
    check("t6_data", {8'd0, iss_data[n_before]}, 32'h421234);
    nack_left = 0;

    // ---------------- 256 entries with no terminator ----------------
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    ack_lat = 1;
    clear_log();
    pulse_start();
    wait_idle(5000, "t7");
    check("t7_n_issued", iss_data.size(),       32'd256);
    check("t7_data_255", {8'd0, iss_data[255]}, 32'h4210FF);
    check("t7_rom_addr", {24'd0, rom_addr},     32'hFF);
    check("t7_done",     {31'd0, config_done},  32'd1);
    repeat (5) @(negedge clk);
    check("t7_no_wrap",  {24'd0, rom_addr},     32'hFF);
    check("t7_busy",     {31'd0, busy},         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
